// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID latch: PC, icache handshake, stall/flush/redirect/halt.
// Define FETCH_PERF_EN to add the fetch_count/stall_count performance counters.
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] iload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [31:0] npc_out,
    output logic        valid_out,
`ifdef FETCH_PERF_EN
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count,
`endif
    output logic        halted
);

    typedef enum logic [0:0] {StRun, StHalted} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcl_q, pcl_d;
    logic [31:0] npc_q, npc_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pcl_d   = pcl_q;
        npc_d   = npc_q;
        valid_d = valid_q;
        if (state_q == StRun) begin
            // Redirect comes from an older instruction, so it beats stall and halt.
            if (redirect_valid) begin
                pc_d    = {redirect_pc[31:2], 2'b00};
                instr_d = 32'h0;
                valid_d = 1'b0;
            end else if (flush) begin
                instr_d = 32'h0;
                valid_d = 1'b0;
            end else if (stall) begin
                pc_d = pc_q;
            end else if (halt) begin
                state_d = StHalted;
                instr_d = 32'h0;
                valid_d = 1'b0;
            end else if (ihit) begin
                instr_d = iload;
                pcl_d   = pc_q;
                npc_d   = pc_plus4;
                valid_d = 1'b1;
                pc_d    = pc_plus4;
            end else begin
                instr_d = 32'h0;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StRun;
            pc_q    <= PC_INIT;
            instr_q <= 32'h0;
            pcl_q   <= 32'h0;
            npc_q   <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcl_q   <= pcl_d;
            npc_q   <= npc_d;
            valid_q <= valid_d;
        end
    end

    assign imemREN   = (state_q == StRun) && !RST;
    assign imemaddr  = pc_q;
    assign halted    = (state_q == StHalted);
    assign instr_out = instr_q;
    assign pc_out    = pcl_q;
    assign npc_out   = npc_q;
    assign valid_out = valid_q;

`ifdef FETCH_PERF_EN
    logic        running;
    logic        fetch_fire;
    logic        stall_fire;
    logic [31:0] fetch_count_q, stall_count_q;

    assign running    = (state_q == StRun);
    assign fetch_fire = running && !redirect_valid && !flush && !stall && !halt && ihit;
    assign stall_fire = running && (stall ||
                        (!redirect_valid && !flush && !halt && !ihit));

    always_ff @(posedge CLK) begin
        if (RST) begin
            fetch_count_q <= 32'h0;
            stall_count_q <= 32'h0;
        end else begin
            if (fetch_fire && (fetch_count_q != 32'hFFFF_FFFF)) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
            if (stall_fire && (stall_count_q != 32'hFFFF_FFFF)) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed test-plan sequence followed by random
// stimulus, with every cycle compared against a behavioural model.
module tb_fetch_stage;

    localparam logic [31:0] PC_INIT = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        ihit = 1'b0;
    logic [31:0] iload = 32'h0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        halt = 1'b0;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [31:0] npc_out;
    logic        valid_out;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    fetch_stage #(.PC_INIT(PC_INIT)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .ihit           (ihit),
        .iload          (iload),
        .imemREN        (imemREN),
        .imemaddr       (imemaddr),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .instr_out      (instr_out),
        .pc_out         (pc_out),
        .npc_out        (npc_out),
        .valid_out      (valid_out),
`ifdef FETCH_PERF_EN
        .fetch_count    (fetch_count),
        .stall_count    (stall_count),
`endif
        .halted         (halted)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    // Architectural view of the stage.
    logic [31:0] m_pc, m_instr, m_pcout, m_npc;
    logic        m_valid, m_halted;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_edge();
        if (RST) begin
            m_pc = PC_INIT; m_halted = 1'b0; m_instr = 0; m_pcout = 0; m_npc = 0;
            m_valid = 1'b0;
        end else if (!m_halted) begin
            if (redirect_valid) begin
                m_pc = redirect_pc & ~32'd3;
                m_instr = 0; m_valid = 1'b0;
            end else if (flush) begin
                m_instr = 0; m_valid = 1'b0;
            end else if (stall) begin
                m_valid = m_valid;
            end else if (halt) begin
                m_halted = 1'b1; m_instr = 0; m_valid = 1'b0;
            end else if (ihit) begin
                m_instr = iload; m_pcout = m_pc; m_npc = m_pc + 32'd4; m_valid = 1'b1;
                m_pc = m_pc + 32'd4;
            end else begin
                m_instr = 0; m_valid = 1'b0;
            end
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("imemREN", {31'h0, imemREN}, {31'h0, !m_halted && !RST});
            chk("imemaddr", imemaddr, m_pc);
            chk("instr_out", instr_out, m_instr);
            chk("pc_out", pc_out, m_pcout);
            chk("npc_out", npc_out, m_npc);
            chk("valid_out", {31'h0, valid_out}, {31'h0, m_valid});
            chk("halted", {31'h0, halted}, {31'h0, m_halted});
        end
    end

    task automatic drive(input logic r, input logic h, input logic [31:0] ld, input logic st,
                         input logic fl, input logic rv, input logic [31:0] rp,
                         input logic hl);
        RST = r; ihit = h; iload = ld; stall = st; flush = fl;
        redirect_valid = rv; redirect_pc = rp; halt = hl;
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic fetch(input logic [31:0] ld);
        drive(1'b0, 1'b1, ld, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk_en = 1'b1;
        chk("rst_valid", {31'h0, valid_out}, 32'h0);
        chk("rst_instr", instr_out, 32'h0);
        chk("rst_addr", imemaddr, 32'h0);

        fetch(32'hAAAA_0001);
        fetch(32'hBBBB_0002);
        chk("b_pc_out", pc_out, 32'h4);
        chk("b_npc_out", npc_out, 32'h8);
        fetch(32'hCCCC_0003);
        chk("c_instr", instr_out, 32'hCCCC_0003);
        chk("c_pc_out", pc_out, 32'h8);
        chk("c_npc_out", npc_out, 32'hC);
        chk("c_addr", imemaddr, 32'hC);

        fetch(32'hDDDD_0004);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("miss_valid", {31'h0, valid_out}, 32'h0);
        chk("miss_addr", imemaddr, 32'h10);
        fetch(32'h8C41_0004);
        chk("lw_instr", instr_out, 32'h8C41_0004);
        chk("lw_pc_out", pc_out, 32'h10);

        fetch(32'h0000_0014);
        fetch(32'h0000_0018);
        fetch(32'h0000_001C);
        drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("stall_addr", imemaddr, 32'h20);
        chk("stall_instr", instr_out, 32'h0000_001C);
        fetch(32'h0000_0020);
        chk("unstall_instr", instr_out, 32'h0000_0020);
        chk("unstall_pc_out", pc_out, 32'h20);

        drive(1'b0, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b1, 32'h103, 1'b1);
        chk("redir_addr", imemaddr, 32'h100);
        chk("redir_valid", {31'h0, valid_out}, 32'h0);
        chk("redir_halted", {31'h0, halted}, 32'h0);
        fetch(32'h0000_0100);
        chk("redir_pc_out", pc_out, 32'h100);

        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("halt_halted", {31'h0, halted}, 32'h1);
        chk("halt_ren", {31'h0, imemREN}, 32'h0);
        fetch(32'h5555_5555);
        drive(1'b0, 1'b1, 32'h6666_6666, 1'b0, 1'b0, 1'b1, 32'h400, 1'b0);
        chk("halt_addr", imemaddr, 32'h104);
        chk("halt_pc_out", pc_out, 32'h100);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("rst2_addr", imemaddr, PC_INIT);
        chk("rst2_halted", {31'h0, halted}, 32'h0);

        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        chk("wrap_pre_addr", imemaddr, 32'hFFFF_FFFC);
        fetch(32'h0BAD_F00D);
        chk("wrap_npc", npc_out, 32'h0);
        chk("wrap_addr", imemaddr, 32'h0);
        chk("wrap_pc_out", pc_out, 32'hFFFF_FFFC);

        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 9) < 7),
                  $urandom,
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 9) == 0),
                  $urandom,
                  ($urandom_range(0, 39) == 0));
        end

        @(negedge CLK);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
